// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers and their counters.
package pipe_pkg;

  localparam int PIPE_WIDTH_DEF = 32;
  localparam int PIPE_CNT_W_DEF = 16;
  localparam logic [PIPE_WIDTH_DEF-1:0] PIPE_FLUSH_VAL_DEF = '0;

  // Default-width stage entry; stages with other widths use the same {valid, data} layout.
  typedef struct packed {
    logic                      valid;
    logic [PIPE_WIDTH_DEF-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, cleared only by rst.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with bubble collapse, optional one-entry skid slot and stall counter.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int                 WIDTH     = PIPE_WIDTH_DEF,
  parameter int                 LANES     = 1,
  parameter logic [WIDTH-1:0]   FLUSH_VAL = WIDTH'(PIPE_FLUSH_VAL_DEF),
  parameter int                 SKID_EN   = 1,
  parameter int                 CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clrBU,
  input  logic                   in_valid,
  input  logic [WIDTH*LANES-1:0] in_data,
  output logic                   stall_up,
  output logic                   out_valid,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int DW = WIDTH * LANES;
  localparam logic [DW-1:0] FLUSH_DATA = {LANES{FLUSH_VAL}};

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } entry_t;

  localparam entry_t FLUSH_ENTRY = '{valid: 1'b0, data: FLUSH_DATA};

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t inEntry;
  logic   cntInc;

  assign inEntry = '{valid: in_valid, data: in_data};

  // With a skid slot the upstream stall is registered; without one it follows enable directly.
  assign stall_up = (SKID_EN != 0) ? skid_q.valid : enable;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (clrBU) begin
      main_d = FLUSH_ENTRY;
      skid_d = FLUSH_ENTRY;
    end else if (!enable) begin
      if (skid_q.valid) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else begin
        main_d = inEntry;
      end
    end else if ((SKID_EN != 0) && !skid_q.valid) begin
      // Held: fill an empty main slot, otherwise park the offered item in the skid slot.
      if (!main_q.valid) begin
        main_d = inEntry;
      end else if (in_valid) begin
        skid_d = inEntry;
      end
    end
    if (SKID_EN == 0) begin
      skid_d = FLUSH_ENTRY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= FLUSH_ENTRY;
      skid_q <= FLUSH_ENTRY;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // A flush cycle leaves the stall count untouched.
  assign cntInc = enable & main_q.valid & ~clrBU;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cntInc),
    .count(stall_cnt)
  );

  assign out_valid = main_q.valid;
  assign out_data  = main_q.data;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst, enable, clrBU, in_valid;
  logic [31:0] in_data;

  logic        stallUp, outValid;
  logic [31:0] outData;
  logic [15:0] stallCnt;
  logic        stallUpS, outValidS;
  logic [31:0] outDataS;
  logic [3:0]  stallCntS;
  logic        stallUpN, outValidN;
  logic [31:0] outDataN;
  logic [15:0] stallCntN;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: main slot plus a queue holding at most one skidded item.
  logic        mVal;
  logic [31:0] mDat;
  logic [31:0] pend[$];
  int          cnt, cntSat;
  logic        nVal;
  logic [31:0] nDat;
  int          nCnt;

  pipe_reg_skid dut (
    .clk(clk), .rst(rst), .enable(enable), .clrBU(clrBU), .in_valid(in_valid),
    .in_data(in_data), .stall_up(stallUp), .out_valid(outValid), .out_data(outData),
    .stall_cnt(stallCnt)
  );

  pipe_reg_skid #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .enable(enable), .clrBU(clrBU), .in_valid(in_valid),
    .in_data(in_data), .stall_up(stallUpS), .out_valid(outValidS), .out_data(outDataS),
    .stall_cnt(stallCntS)
  );

  pipe_reg_skid #(.SKID_EN(0)) dutNoSkid (
    .clk(clk), .rst(rst), .enable(enable), .clrBU(clrBU), .in_valid(in_valid),
    .in_data(in_data), .stall_up(stallUpN), .out_valid(outValidN), .out_data(outDataN),
    .stall_cnt(stallCntN)
  );

  always #5 clk = ~clk;

  // Advance the model with the currently driven inputs, then clock and settle.
  task automatic cycle();
    if (rst) begin
      mVal = 1'b0; mDat = '0; pend.delete(); cnt = 0; cntSat = 0;
      nVal = 1'b0; nDat = '0; nCnt = 0;
    end else if (clrBU) begin
      mVal = 1'b0; mDat = '0; pend.delete();
      nVal = 1'b0; nDat = '0;
    end else begin
      if (enable && mVal) begin
        if (cnt < 65535) cnt++;
        if (cntSat < 15) cntSat++;
      end
      if (enable && nVal && nCnt < 65535) nCnt++;
      if (!enable) begin
        if (pend.size() > 0) begin
          mVal = 1'b1;
          mDat = pend.pop_front();
        end else begin
          mVal = in_valid;
          mDat = in_data;
        end
        nVal = in_valid;
        nDat = in_data;
      end else if (pend.size() == 0) begin
        if (!mVal) begin
          mVal = in_valid;
          mDat = in_data;
        end else if (in_valid) begin
          pend.push_back(in_data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clrBU = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    cycle();
    cycle();
    testsRun++;
    if ({outValid, outData} !== {1'b0, 32'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_out: got valid=%b data=%h, want valid=0 data=0", outValid, outData);
    end
    testsRun++;
    if ({stallUp, stallCnt, stallCntS} !== {1'b0, 16'h0, 4'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_stall: got stall_up=%b cnt=%0d sat=%0d, want 0 0 0",
               stallUp, stallCnt, stallCntS);
    end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals[0] = 32'h4; vals[1] = 32'h8; vals[2] = 32'hC;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      cycle();
      testsRun++;
      if ({stallUp, outValid, outData} !== {1'b0, 1'b1, vals[i]}) begin
        failCount++;
        $display("[TB] FAIL stream_%0d: got stall=%b valid=%b data=%h, want 0 1 %h",
                 i, stallUp, outValid, outData, vals[i]);
      end
    end
  endtask

  task automatic test_skid();
    enable = 1'b0; in_valid = 1'b1; in_data = 32'h10;
    cycle();
    enable = 1'b1; in_data = 32'h14;
    cycle();
    testsRun++;
    if ({stallUp, outValid, outData} !== {1'b1, 1'b1, 32'h10}) begin
      failCount++;
      $display("[TB] FAIL skid_capture: got stall=%b valid=%b data=%h, want 1 1 00000010",
               stallUp, outValid, outData);
    end
    testsRun++;
    if (stallCnt !== 16'(cnt)) begin
      failCount++;
      $display("[TB] FAIL skid_cnt: got %0d, want %0d", stallCnt, cnt);
    end
    // Next item offered by upstream is held (and ignored) while stall_up is high.
    in_data = 32'h18; enable = 1'b0;
    cycle();
    testsRun++;
    if ({stallUp, outValid, outData} !== {1'b0, 1'b1, 32'h14}) begin
      failCount++;
      $display("[TB] FAIL skid_drain: got stall=%b valid=%b data=%h, want 0 1 00000014",
               stallUp, outValid, outData);
    end
    cycle();
    testsRun++;
    if ({outValid, outData} !== {1'b1, 32'h18}) begin
      failCount++;
      $display("[TB] FAIL skid_after: got valid=%b data=%h, want 1 00000018", outValid, outData);
    end
  endtask

  task automatic test_flush();
    logic [15:0] savedCnt;
    enable = 1'b0; in_valid = 1'b1; in_data = 32'h20;
    cycle();
    enable = 1'b1; in_data = 32'h24;
    cycle();
    testsRun++;
    if (stallUp !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL flush_setup: got stall_up=%b, want 1", stallUp);
    end
    savedCnt = stallCnt;
    clrBU = 1'b1;
    cycle();
    clrBU = 1'b0;
    testsRun++;
    if ({stallUp, outValid, outData} !== {1'b0, 1'b0, 32'h0}) begin
      failCount++;
      $display("[TB] FAIL flush_out: got stall=%b valid=%b data=%h, want 0 0 0",
               stallUp, outValid, outData);
    end
    testsRun++;
    if (stallCnt !== savedCnt) begin
      failCount++;
      $display("[TB] FAIL flush_cnt: got %0d, want %0d", stallCnt, savedCnt);
    end
  endtask

  task automatic test_bubble();
    enable = 1'b1; in_valid = 1'b1; in_data = 32'h30;
    cycle();
    testsRun++;
    if ({outValid, outData} !== {1'b1, 32'h30}) begin
      failCount++;
      $display("[TB] FAIL bubble: got valid=%b data=%h, want 1 00000030", outValid, outData);
    end
    testsRun++;
    if ({stallUpN, outValidN} !== {1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL bubble_noskid: got stall=%b valid=%b, want 1 0", stallUpN, outValidN);
    end
  endtask

  task automatic test_saturation();
    enable = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      testsRun++;
      if (stallCntS !== 4'(cntSat)) begin
        failCount++;
        $display("[TB] FAIL sat_step_%0d: got %0d, want %0d", i, stallCntS, cntSat);
      end
    end
    testsRun++;
    if (stallCntS !== 4'hF) begin
      failCount++;
      $display("[TB] FAIL sat_final: got %0d, want 15", stallCntS);
    end
  endtask

  task automatic test_reset_midstall();
    enable = 1'b1; in_valid = 1'b1; in_data = 32'h40;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    testsRun++;
    if ({stallUp, outValid, stallCnt} !== {1'b0, 1'b0, 16'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_midstall: got stall=%b valid=%b cnt=%0d, want 0 0 0",
               stallUp, outValid, stallCnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      clrBU  = ($urandom_range(0, 19) == 0);
      enable = ($urandom_range(0, 9) < 4);
      if (pend.size() == 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
      end
      cycle();
      testsRun++;
      if ({stallUp, outValid, outData} !== {pend.size() != 0, mVal, mDat}) begin
        failCount++;
        $display("[TB] FAIL rand_main_%0d: got stall=%b valid=%b data=%h, want %b %b %h",
                 i, stallUp, outValid, outData, pend.size() != 0, mVal, mDat);
      end
      testsRun++;
      if ({stallCnt, stallCntS} !== {16'(cnt), 4'(cntSat)}) begin
        failCount++;
        $display("[TB] FAIL rand_cnt_%0d: got %0d/%0d, want %0d/%0d",
                 i, stallCnt, stallCntS, cnt, cntSat);
      end
      testsRun++;
      if ({stallUpN, outValidN, outDataN, stallCntN} !== {enable, nVal, nDat, 16'(nCnt)}) begin
        failCount++;
        $display("[TB] FAIL rand_noskid_%0d: got stall=%b valid=%b data=%h cnt=%0d, want %b %b %h %0d",
                 i, stallUpN, outValidN, outDataN, stallCntN, enable, nVal, nDat, nCnt);
      end
    end
    rst = 1'b0; clrBU = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_bubble();
    test_saturation();
    test_reset_midstall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline stage register, the successor to the single-field decode-stage latches.
- Carries LANES packed fields of WIDTH bits each, with a valid bit, active-low load enable and branch-unit flush.
- Adds bubble collapse, an optional one-entry skid slot so the upstream stall can be registered, and a saturating stall counter.
- Instantiated between every pipeline stage pair (fetch/decode, decode/execute, ...).

Parameters:
- WIDTH, 32, bits per lane.
- LANES, 1, number of fields carried; data bus width is WIDTH*LANES.
- FLUSH_VAL, 0, value loaded into every lane on flush and reset.
- SKID_EN, 1, 1 = skid slot present and stall_up registered; 0 = no skid, stall_up = enable combinationally.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  active-low load: 0 = advance, 1 = downstream stall.
- clrBU  in  1  synchronous flush from branch unit.
- in_valid  in  1  upstream item valid.
- in_data  in  WIDTH*LANES  upstream payload.
- stall_up  out  1  stall request to upstream stage.
- out_valid  out  1  main register valid.
- out_data  out  WIDTH*LANES  main register payload.
- stall_cnt  out  CNT_W  cycles held with a valid item.

Behaviour:
- State: main {valid, data}; skid {valid, data} when SKID_EN=1.
- Priority per cycle: rst > clrBU > enable/in logic.
- rst:
  - main.valid = skid.valid = 0; main.data = skid.data = FLUSH_VAL in every lane.
  - stall_cnt = 0; stall_up = 0.
- clrBU:
  - Same as rst for both valids and both datas.
  - stall_cnt holds.
  - clrBU together with enable=1 still flushes; the in-flight item is dropped.
- stall_up = skid.valid (registered). Upstream holds in_data/in_valid while stall_up=1; this block ignores in_* whenever stall_up=1.
- Advance (enable=0):
  - If skid.valid: main <= skid; skid.valid <= 0.
  - Else: main.data <= in_data; main.valid <= in_valid.
  - Latency in -> out: 1 cycle.
- Hold (enable=1):
  - If !main.valid and !stall_up: main <= in (bubble collapse); main.valid <= in_valid.
  - Else if main.valid and !skid.valid and in_valid: skid <= in; skid.valid <= 1.
  - Else: no state change.
- SKID_EN=0:
  - No skid storage; stall_up = enable.
  - Hold keeps main unconditionally, including while main is invalid.
  - No bubble collapse.
- stall_cnt:
  - Increments when enable=1 and main.valid=1.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- out_data is held stable whenever main does not load. Invalid entries still present data; consumers must qualify with out_valid.
- Reset asserted mid-stall: the skid contents are discarded; stall_up is low the next cycle.

Decomposition:
- pipe_pkg holds:
  - typedef pipe_entry_t {valid, data};
  - the default FLUSH_VAL constant;
  - the stall counter width default.
- Sub-module: pipe_sat_counter (CNT_W, inc, rst, count). Reused by the performance counters.
- Main and skid slots are inline registers in pipe_reg_skid.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, out_data=0, stall_up=0, stall_cnt=0.
- Streaming: enable=0, in_data 0x4,0x8,0xC on consecutive cycles -> out_data 0x4,0x8,0xC one cycle later each; out_valid=1; stall_up never asserts.
- Skid capture and drain:
  - main=0x10 valid; raise enable=1 while in_data=0x14 valid -> skid captures 0x14, stall_up=1 next cycle, out_data stays 0x10.
  - Drop enable -> out_data=0x14, then stall_up=0.
- Flush during stall: main=0x20, skid=0x24, enable=1, pulse clrBU -> out_valid=0, stall_up=0, out_data=FLUSH_VAL, stall_cnt unchanged.
- Bubble collapse: main invalid, enable=1, in_data=0x30 valid -> out_valid=1, out_data=0x30 next cycle.
- Counter saturation: CNT_W=4, hold valid stall for 20 cycles -> stall_cnt reaches 15 and stays 15.
